// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI write or read out, one response back.
// A per-transaction timeout abandons a hung slave and reports resp 2'b11 with a sticky error flag.
module axil_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  input  logic [3:0]            i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [31:0]           o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_timeout_err,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [31:0]           i_rdata,
  input  logic [1:0]            i_rresp,
  output logic [2:0]            o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // every valid is held until its transfer (except when a timeout aborts the transaction).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                state, state_n;
  logic [31:0]           cnt, cnt_n;
  logic                  cmd_ready_n, rsp_valid_n, rsp_write_n, timeout_err_n;
  logic [31:0]           rsp_rdata_n;
  logic [1:0]            rsp_resp_n;
  logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [ADDR_WIDTH-1:0] awaddr_n, araddr_n;
  logic [31:0]           wdata_n;
  logic [3:0]            wstrb_n;
  logic                  active, expired, complete, aw_done, w_done;

  assign o_dbg_state = state;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    cmd_ready_n   = o_cmd_ready;
    rsp_valid_n   = o_rsp_valid;
    rsp_write_n   = o_rsp_write;
    rsp_rdata_n   = o_rsp_rdata;
    rsp_resp_n    = o_rsp_resp;
    timeout_err_n = o_timeout_err;
    awvalid_n     = o_awvalid;
    wvalid_n      = o_wvalid;
    bready_n      = o_bready;
    arvalid_n     = o_arvalid;
    rready_n      = o_rready;
    awaddr_n      = o_awaddr;
    araddr_n      = o_araddr;
    wdata_n       = o_wdata;
    wstrb_n       = o_wstrb;

    active   = (state == S_WRITE) || (state == S_WRESP) || (state == S_READ) || (state == S_RDATA);
    complete = ((state == S_WRESP) && i_bvalid && o_bready) ||
               ((state == S_RDATA) && i_rvalid && o_rready);
    expired  = active && (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    aw_done  = !o_awvalid || i_awready;
    w_done   = !o_wvalid || i_wready;

    if (active && (cnt != '1)) cnt_n = cnt + 32'd1;

    case (state)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          cmd_ready_n = 1'b0;
          cnt_n       = '0;
          rsp_write_n = i_cmd_write;
          if (i_cmd_write) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = i_cmd_addr;
            wdata_n   = i_cmd_wdata;
            wstrb_n   = i_cmd_wstrb;
            state_n   = S_WRITE;
          end else begin
            arvalid_n = 1'b1;
            araddr_n  = i_cmd_addr;
            state_n   = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (i_awready) awvalid_n = 1'b0;
        if (i_wready)  wvalid_n  = 1'b0;
        if (aw_done && w_done) begin
          bready_n = 1'b1;
          state_n  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (i_bvalid) begin
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_resp_n  = i_bresp;
          rsp_rdata_n = '0;
          state_n     = S_RSP;
        end
      end
      S_READ: begin
        if (i_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (i_rvalid) begin
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_resp_n  = i_rresp;
          rsp_rdata_n = i_rdata;
          state_n     = S_RSP;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A completing B/R handshake on the expiry cycle takes precedence over the abort.
    if (expired && !complete) begin
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      arvalid_n     = 1'b0;
      bready_n      = 1'b0;
      rready_n      = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_resp_n    = 2'b11;
      rsp_rdata_n   = '0;
      timeout_err_n = 1'b1;
      state_n       = S_RSP;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      o_cmd_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_write   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= '0;
      o_timeout_err <= 1'b0;
      o_awvalid     <= 1'b0;
      o_wvalid      <= 1'b0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_rready      <= 1'b0;
      o_awaddr      <= '0;
      o_araddr      <= '0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      o_cmd_ready   <= cmd_ready_n;
      o_rsp_valid   <= rsp_valid_n;
      o_rsp_write   <= rsp_write_n;
      o_rsp_rdata   <= rsp_rdata_n;
      o_rsp_resp    <= rsp_resp_n;
      o_timeout_err <= timeout_err_n;
      o_awvalid     <= awvalid_n;
      o_wvalid      <= wvalid_n;
      o_bready      <= bready_n;
      o_arvalid     <= arvalid_n;
      o_rready      <= rready_n;
      o_awaddr      <= awaddr_n;
      o_araddr      <= araddr_n;
      o_wdata       <= wdata_n;
      o_wstrb       <= wstrb_n;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed scenarios plus randomized slave delays, checked against a
// transaction-level model that predicts response content, latency and per-channel valid/ready counts.
module tb_axil_cmd_master;

  localparam int AW = 32;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout_err;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [2:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  bit sticky = 1'b0;
  logic [34:0] exp_q[$];

  axil_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .i_aclk(clk), .i_areset(areset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_timeout_err(timeout_err),
    .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr),
    .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
    .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  // One full transaction. For reads d_a is the AR delay and d_b the R delay after rready.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int d_a, input int d_w, input int d_b,
                         input logic [1:0] sresp, input logic [31:0] srdata, input int hold);
    int m, c, exp_idx, exp_rdy_n, exp_rdy_first, got_idx, aw_n, w_n, ar_n, rdy_n, rdy_first, wait_n;
    bit to;
    logic [34:0] exp_rsp;

    // reference model: cycle index 0 is the first cycle after the accepting edge
    m  = wr ? ((d_a > d_w) ? d_a : d_w) : d_a;
    c  = m + 1 + d_b;
    to = (c > T - 1);
    exp_idx       = to ? T : c + 1;
    exp_rdy_n     = (m + 1 <= T - 1) ? (((c < T - 1) ? c : T - 1) - m) : 0;
    exp_rdy_first = (exp_rdy_n > 0) ? m + 1 : -1;
    if (to) begin
      sticky = 1'b1;
      exp_q.push_back({wr, 2'b11, 32'h0});
    end else begin
      exp_q.push_back({wr, sresp, wr ? 32'h0 : srdata});
    end

    wait_n = 0;
    while (!cmd_ready && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("cmd_ready_before_cmd", 64'(cmd_ready), 64'(1));

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);

    aw_n = 0; w_n = 0; ar_n = 0; rdy_n = 0; rdy_first = -1; got_idx = -1;
    for (int idx = 0; idx < 40; idx++) begin
      if (rsp_valid) begin
        got_idx = idx;
        break;
      end
      if (idx == 0) begin
        if (wr) begin
          check("awaddr", 64'(awaddr), 64'(addr));
          check("wdata_wstrb", {28'h0, wstrb, wdata}, {28'h0, strb, data});
        end else begin
          check("araddr", 64'(araddr), 64'(addr));
        end
      end
      if (awvalid) aw_n++;
      if (wvalid) w_n++;
      if (arvalid) ar_n++;
      if (bready || rready) begin
        if (rdy_first < 0) rdy_first = idx;
        rdy_n++;
      end
      awready = (idx >= d_a) && wr;
      wready  = (idx >= d_w) && wr;
      arready = (idx >= d_a) && !wr;
      if (rdy_first >= 0 && (bready || rready) && (idx - rdy_first) >= d_b) begin
        bvalid = wr;  bresp = sresp;
        rvalid = !wr; rresp = sresp; rdata = srdata;
      end else begin
        bvalid = 1'b0; bresp = 2'($urandom);
        rvalid = 1'b0; rresp = 2'($urandom); rdata = $urandom;
      end
      tick();
    end
    quiet_slave();

    check("rsp_latency", 64'(got_idx), 64'(exp_idx));
    if (wr) begin
      check("awvalid_cycles", 64'(aw_n), 64'((d_a + 1 < T) ? d_a + 1 : T));
      check("wvalid_cycles", 64'(w_n), 64'((d_w + 1 < T) ? d_w + 1 : T));
    end else begin
      check("arvalid_cycles", 64'(ar_n), 64'((d_a + 1 < T) ? d_a + 1 : T));
    end
    check("ready_cycles", 64'(rdy_n), 64'(exp_rdy_n));
    check("ready_first", 64'(rdy_first), 64'(exp_rdy_first));

    exp_rsp = exp_q.pop_front();
    check("rsp_fields", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(exp_rsp));
    check("timeout_err", 64'(timeout_err), 64'(sticky));

    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = $urandom; cmd_addr = $urandom;
      tick();
      check("hold_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, exp_rsp}));
      check("hold_quiet", 64'({cmd_ready, awvalid, wvalid, arvalid}), 64'(0));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("back_to_idle", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  task automatic reset_mid_write();
    wait_n_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h1234_5678;
    cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_write_awvalid", 64'({awvalid, wvalid}), 64'(2'b11));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    sticky = 1'b0;
    check("reset_mid_ctrl",
          64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err, cmd_ready}),
          64'(8'b0000_0001));
  endtask

  task automatic wait_n_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 10) begin
      tick();
      k++;
    end
  endtask

  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    quiet_slave();
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
    tick();
    check("reset_ctrl",
          64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err, cmd_ready}),
          64'(8'b0000_0001));
    check("reset_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));

    // directed scenarios
    run_txn(1'b1, 32'h0000_0010, 32'h0000_0040, 4'hF, 3, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 2, 2'b00, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 100, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b1, 32'h0000_000C, 32'h5, 4'h3, 0, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b1, 32'h0000_0014, 32'hA5A5_0001, 4'hF, 3, 0, 3, 2'b10, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0018, 32'h0, 4'h0, 1, 0, 1, 2'b01, 32'hCAFE_F00D, 10);
    reset_mid_write();
    run_txn(1'b1, 32'h0000_001C, 32'h7, 4'h1, 0, 2, 4, 2'b00, 32'h0, 1);
    run_txn(1'b1, 32'h0000_0024, 32'h8, 4'h1, 1, 5, 1, 2'b00, 32'h0, 0);

    // randomized slave timing and response content
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
              2'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
